led_matrix_scanner: RTL and testbench
=====================================

Name: led_matrix_scanner

Overview:
Time-multiplexed scan controller for the 8-row x 4-column LED matrix driven on LED_R0..LED_R7 / LED_C0..LED_C3. Game logic hands it a complete 32-bit frame over a valid/ready handshake. The block double-buffers the frame and swaps buffers only at frame boundaries, so the display never tears. It drives one column at a time, with a programmable dwell window and an all-off blanking gap between columns to suppress ghosting.

Parameters:
DWELL_CYCLES, 50000, cycles a column is driven per visit (1 ms at 50 MHz); must be >= 1
BLANK_CYCLES, 500, all-off cycles before each column visit; 0 = no blanking
CNT_W, $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1), width of the window counter (derived; do not override)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
ENABLE  in  1  1 = scan; 0 = display dark, scan parked
FRAME_IN  in  32  frame; bit c*8+r = LED at row r, column c (1 = lit)
FRAME_VALID  in  1  FRAME_IN valid
FRAME_READY  out  1  pending buffer empty; transfer occurs when VALID & READY
FRAME_DONE  out  1  one-cycle pulse at each frame boundary while scanning
LED_R0..LED_R7  out  1 each  row data, active-high
LED_C0..LED_C3  out  1 each  column select, active-low

Behaviour:
- Reset (RST high at a clock edge):
  - state=IDLE, column index=0, counter=0, active buffer=0, pending empty.
  - All LED_R*=0, all LED_C*=1, FRAME_DONE=0.
  - FRAME_READY is forced 0 while RST is high; a VALID in that cycle is dropped.
  - Reset mid-scan takes effect at the same edge; the aborted frame is discarded.
- FRAME_READY = !pend_full & !RST.
  - Transfer: FRAME_IN goes into the pending buffer and pend_full is set next cycle.
  - While READY=0, FRAME_IN is ignored. The requester holds VALID and data until READY.
- States: IDLE, BLANK, DRIVE. All outputs are registered and coherent with the state register.
  - IDLE: all outputs off. Move to BLANK with col=0 when ENABLE=1 (to DRIVE if BLANK_CYCLES=0). Leaving IDLE is a frame boundary for swap purposes, but FRAME_DONE does not pulse.
  - BLANK: all LED_C*=1, all LED_R*=0, exactly BLANK_CYCLES cycles, then DRIVE with the same col.
  - DRIVE: LED_C[col]=0, other columns 1; LED_R[r]=active[col*8+r]. Lasts exactly DWELL_CYCLES cycles, then col=col+1 mod 4 and go to BLANK (or DRIVE if BLANK_CYCLES=0).
- Frame boundary is the DRIVE col3 -> col0 transition.
  - At the boundary, if pend_full: active <= pending, pend_full <= 0. FRAME_READY rises the following cycle.
  - FRAME_DONE=1 in the first cycle of the col0 window.
  - Frame period = 4*(BLANK_CYCLES+DWELL_CYCLES) cycles exactly.
- Latency: an accepted frame becomes visible in the col0 DRIVE window after the next boundary. There is no mid-frame update.
- Simultaneous swap and VALID: READY=0 in the swap cycle (pend_full still 1), so no accept occurs that cycle.
- ENABLE deasserted in any state: IDLE next cycle, outputs off, col and counter cleared. The pending buffer is kept and transfers remain possible.
- No frame ever accepted: the active buffer of 0 is scanned (dark display), with timing unchanged.

Decomposition:
- Package led_scan_pkg holds:
  - NUM_ROWS=8, NUM_COLS=4
  - state encoding for IDLE/BLANK/DRIVE
  - LED_ROW_ON=1, LED_COL_ON=0 polarity constants
  - frame bit-index function (col,row) -> col*8+row
- Sub-module scan_window_timer: loadable down-counter of width CNT_W with load value, load strobe and single-cycle expire output. It is instantiated once and reused for BLANK and DRIVE windows.

Test Plan:
(All scenarios use DWELL_CYCLES=4, BLANK_CYCLES=2, so the frame period is 24.)
1. Reset: RST=1 for 2 cycles with FRAME_VALID=1 -> FRAME_READY=0, LED_C*=1, LED_R*=0 during reset. After release READY=1 and the dropped frame is never displayed.
2. Accept 32'hA5C3_0FF0, ENABLE=1 -> after the boundary:
   - per column: 2 cycles all-off, then 4 cycles driven
   - col0 rows=8'hF0, col1=8'h0F, col2=8'hC3, col3=8'hA5
   - exactly one LED_C low at a time
   - FRAME_DONE pulses every 24 cycles
3. Double buffer:
   - accept 32'h0000_00FF, then present 32'hFF00_0000 immediately -> READY=0 and the second frame is held
   - old frame is still shown until the boundary; the first frame is then visible and READY returns 1 one cycle after the swap
   - second frame is accepted next and shown one boundary later
4. ENABLE drop during col2 DRIVE -> all outputs off next cycle. Reassert after 5 cycles -> 2 blank cycles, then col0 driven, with no FRAME_DONE pulse on resume.
5. RST asserted mid-DRIVE col1 with a frame pending -> next cycle all off, READY=1 after release, active=0, pending discarded.
6. BLANK_CYCLES=0 variant -> columns are driven back-to-back for 4 cycles each, period 16, FRAME_DONE every 16 cycles.

Source files
------------

// File: rtl/led_matrix_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module : led_scan_pkg
// Brief  : Shared geometry, polarity and state encoding for the LED matrix scanner
// Rev    : 1.0 - initial release
// ============================================================================
package led_scan_pkg;

    localparam int NUM_ROWS = 8;
    localparam int NUM_COLS = 4;
    localparam int FRAME_W  = NUM_ROWS * NUM_COLS;
    localparam int ROW_W    = $clog2(NUM_ROWS);
    localparam int COL_W    = $clog2(NUM_COLS);
    localparam int BIT_W    = $clog2(FRAME_W);

    localparam logic LED_ROW_ON = 1'b1;
    localparam logic LED_COL_ON = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_t;

    function automatic logic [BIT_W-1:0] frame_bit(input logic [COL_W-1:0] col,
                                                   input logic [ROW_W-1:0] row);
        return BIT_W'(col * NUM_ROWS + row);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_matrix_scanner_timer.sv
`default_nettype none
// ============================================================================
// Module : scan_window_timer
// Brief  : Loadable down-counter; o_expire flags the last cycle of a window
// Rev    : 1.0 - initial release
// ============================================================================
module scan_window_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_expire
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // A window loaded with N expires on its Nth cycle; zero parks the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_one;
        end
    end

    assign o_expire = (r_cnt == c_one);

endmodule
`default_nettype wire

// File: rtl/led_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module : led_matrix_scanner
// Brief  : Double-buffered 8x4 LED matrix column scanner with blanking gaps
// Rev    : 1.0 - initial release
// ============================================================================
module led_matrix_scanner
    import led_scan_pkg::*;
#(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W = $clog2(((DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES) + 1)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic [31:0] FRAME_IN,
    input  logic        FRAME_VALID,
    output logic        FRAME_READY,
    output logic        FRAME_DONE,
    output logic        LED_R0,
    output logic        LED_R1,
    output logic        LED_R2,
    output logic        LED_R3,
    output logic        LED_R4,
    output logic        LED_R5,
    output logic        LED_R6,
    output logic        LED_R7,
    output logic        LED_C0,
    output logic        LED_C1,
    output logic        LED_C2,
    output logic        LED_C3
);

    localparam logic [CNT_W-1:0] c_dwell_load = CNT_W'(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] c_blank_load = CNT_W'(BLANK_CYCLES);
    localparam logic [COL_W-1:0] c_last_col   = COL_W'(NUM_COLS - 1);
    localparam logic [COL_W-1:0] c_col_one    = COL_W'(1);

    scan_state_t         r_state, w_state_nxt;
    logic [COL_W-1:0]    r_col, w_col_nxt;
    logic [FRAME_W-1:0]  r_active, r_pending, w_active_nxt;
    logic                r_pend_full;
    logic                w_boundary, w_done_nxt, w_load, w_expire, w_ready;
    logic [CNT_W-1:0]    w_load_val;
    logic [NUM_ROWS-1:0] r_row, w_row_nxt;
    logic [NUM_COLS-1:0] r_colsel, w_colsel_nxt;
    logic                r_done;

    scan_window_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (CLK),
        .rst        (RST),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expire   (w_expire)
    );

    assign w_ready = ~r_pend_full & ~RST;

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_boundary  = 1'b0;
        w_done_nxt  = 1'b0;
        if (!ENABLE) begin
            w_state_nxt = ST_IDLE;
            w_col_nxt   = '0;
            w_load      = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Starting a scan swaps buffers but is not a completed frame.
                    w_boundary = 1'b1;
                    w_col_nxt  = '0;
                    w_load     = 1'b1;
                    if (BLANK_CYCLES == 0) begin
                        w_state_nxt = ST_DRIVE;
                        w_load_val  = c_dwell_load;
                    end else begin
                        w_state_nxt = ST_BLANK;
                        w_load_val  = c_blank_load;
                    end
                end
                ST_BLANK: begin
                    if (w_expire) begin
                        w_state_nxt = ST_DRIVE;
                        w_load      = 1'b1;
                        w_load_val  = c_dwell_load;
                    end
                end
                ST_DRIVE: begin
                    if (w_expire) begin
                        w_col_nxt = r_col + c_col_one;
                        w_load    = 1'b1;
                        if (r_col == c_last_col) begin
                            w_boundary = 1'b1;
                            w_done_nxt = 1'b1;
                        end
                        if (BLANK_CYCLES == 0) begin
                            w_state_nxt = ST_DRIVE;
                            w_load_val  = c_dwell_load;
                        end else begin
                            w_state_nxt = ST_BLANK;
                            w_load_val  = c_blank_load;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_col_nxt   = '0;
                    w_load      = 1'b1;
                end
            endcase
        end
    end

    assign w_active_nxt = (w_boundary && r_pend_full) ? r_pending : r_active;

    // Outputs are computed from next-state values so the registers track the state.
    always_comb begin
        w_row_nxt    = {NUM_ROWS{~LED_ROW_ON}};
        w_colsel_nxt = {NUM_COLS{~LED_COL_ON}};
        if (w_state_nxt == ST_DRIVE) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (COL_W'(c) == w_col_nxt) begin
                    w_colsel_nxt[c] = LED_COL_ON;
                end
            end
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (w_active_nxt[frame_bit(w_col_nxt, ROW_W'(r))]) begin
                    w_row_nxt[r] = LED_ROW_ON;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_col       <= '0;
            r_active    <= '0;
            r_pending   <= '0;
            r_pend_full <= 1'b0;
            r_row       <= {NUM_ROWS{~LED_ROW_ON}};
            r_colsel    <= {NUM_COLS{~LED_COL_ON}};
            r_done      <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_col    <= w_col_nxt;
            r_active <= w_active_nxt;
            r_row    <= w_row_nxt;
            r_colsel <= w_colsel_nxt;
            r_done   <= w_done_nxt;
            if (w_boundary && r_pend_full) begin
                r_pend_full <= 1'b0;
            end else if (FRAME_VALID && w_ready) begin
                r_pending   <= FRAME_IN;
                r_pend_full <= 1'b1;
            end
        end
    end

    assign FRAME_READY = w_ready;
    assign FRAME_DONE  = r_done;
    assign LED_R0 = r_row[0];
    assign LED_R1 = r_row[1];
    assign LED_R2 = r_row[2];
    assign LED_R3 = r_row[3];
    assign LED_R4 = r_row[4];
    assign LED_R5 = r_row[5];
    assign LED_R6 = r_row[6];
    assign LED_R7 = r_row[7];
    assign LED_C0 = r_colsel[0];
    assign LED_C1 = r_colsel[1];
    assign LED_C2 = r_colsel[2];
    assign LED_C3 = r_colsel[3];

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module : tb_led_matrix_scanner
// Brief  : Self-checking bench; unit 0 uses BLANK=2, unit 1 uses BLANK=0
// Rev    : 1.0 - initial release
// ============================================================================
module tb_led_matrix_scanner;

    localparam int DW   = 4;
    localparam int BL_A = 2;
    localparam int BL_B = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, en_a, valid_a, rst_b, en_b, valid_b;
    logic [31:0] frame_a, frame_b;
    wire         ready_a, done_a, ready_b, done_b;
    wire  [7:0]  rows_a, rows_b;
    wire  [3:0]  cols_a, cols_b;

    led_matrix_scanner #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL_A)) dut_a (
        .CLK(clk), .RST(rst_a), .ENABLE(en_a), .FRAME_IN(frame_a),
        .FRAME_VALID(valid_a), .FRAME_READY(ready_a), .FRAME_DONE(done_a),
        .LED_R0(rows_a[0]), .LED_R1(rows_a[1]), .LED_R2(rows_a[2]), .LED_R3(rows_a[3]),
        .LED_R4(rows_a[4]), .LED_R5(rows_a[5]), .LED_R6(rows_a[6]), .LED_R7(rows_a[7]),
        .LED_C0(cols_a[0]), .LED_C1(cols_a[1]), .LED_C2(cols_a[2]), .LED_C3(cols_a[3])
    );

    led_matrix_scanner #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL_B)) dut_b (
        .CLK(clk), .RST(rst_b), .ENABLE(en_b), .FRAME_IN(frame_b),
        .FRAME_VALID(valid_b), .FRAME_READY(ready_b), .FRAME_DONE(done_b),
        .LED_R0(rows_b[0]), .LED_R1(rows_b[1]), .LED_R2(rows_b[2]), .LED_R3(rows_b[3]),
        .LED_R4(rows_b[4]), .LED_R5(rows_b[5]), .LED_R6(rows_b[6]), .LED_R7(rows_b[7]),
        .LED_C0(cols_b[0]), .LED_C1(cols_b[1]), .LED_C2(cols_b[2]), .LED_C3(cols_b[3])
    );

    // Reference model: scan position within the frame period plus the two buffers.
    int          per_blank [2] = '{BL_A, BL_B};
    int          m_pos     [2];
    bit          m_scan    [2];
    bit          m_pend    [2];
    bit          m_done    [2];
    bit          m_acc     [2];
    logic [31:0] m_active  [2];
    logic [31:0] m_pending [2];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input int u, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s unit%0d cycle %0d: observed %h expected %h", tag, u, cyc, obs, exp);
        end
    endtask

    task automatic model_step(input int u, input logic r, input logic e, input logic v,
                              input logic [31:0] f);
        bit rdy;
        bit bnd;
        int period;
        period    = 4 * (per_blank[u] + DW);
        m_acc[u]  = 1'b0;
        m_done[u] = 1'b0;
        bnd       = 1'b0;
        if (r) begin
            m_scan[u]   = 1'b0;
            m_pos[u]    = 0;
            m_active[u] = '0;
            m_pend[u]   = 1'b0;
        end else begin
            rdy = !m_pend[u];
            if (!e) begin
                m_scan[u] = 1'b0;
                m_pos[u]  = 0;
            end else if (!m_scan[u]) begin
                m_scan[u] = 1'b1;
                m_pos[u]  = 0;
                bnd       = 1'b1;
            end else begin
                m_pos[u]++;
                if (m_pos[u] == period) begin
                    m_pos[u]  = 0;
                    bnd       = 1'b1;
                    m_done[u] = 1'b1;
                end
            end
            if (bnd && m_pend[u]) begin
                m_active[u] = m_pending[u];
                m_pend[u]   = 1'b0;
            end else if (v && rdy) begin
                m_pending[u] = f;
                m_pend[u]    = 1'b1;
                m_acc[u]     = 1'b1;
            end
        end
    endtask

    task automatic check_unit(input int u);
        logic [7:0] er;
        logic [3:0] ec;
        logic       ey;
        int         win, col, off;
        er = 8'h00;
        ec = 4'hF;
        if (m_scan[u]) begin
            win = per_blank[u] + DW;
            col = m_pos[u] / win;
            off = m_pos[u] % win;
            if (off >= per_blank[u]) begin
                ec = ~(4'b0001 << col);
                er = 8'(m_active[u] >> (8 * col));
            end
        end
        ey = !m_pend[u] && !((u == 0) ? rst_a : rst_b);
        check("rows",  u, 32'((u == 0) ? rows_a  : rows_b),  32'(er));
        check("cols",  u, 32'((u == 0) ? cols_a  : cols_b),  32'(ec));
        check("done",  u, 32'((u == 0) ? done_a  : done_b),  32'(m_done[u]));
        check("ready", u, 32'((u == 0) ? ready_a : ready_b), 32'(ey));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, rst_a, en_a, valid_a, frame_a);
        model_step(1, rst_b, en_b, valid_b, frame_b);
        #1;
        cyc++;
        check_unit(0);
        check_unit(1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input int u, input logic [31:0] f, input int budget);
        bit got;
        got = 1'b0;
        if (u == 0) begin valid_a = 1'b1; frame_a = f; end
        else        begin valid_b = 1'b1; frame_b = f; end
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            got = m_acc[u];
        end
        if (u == 0) begin valid_a = 1'b0; frame_a = $urandom; end
        else        begin valid_b = 1'b0; frame_b = $urandom; end
        check("send_accept", u, 32'(got), 32'd1);
    endtask

    task automatic wait_pos(input int u, input int p, input int budget);
        bit found;
        for (int i = 0; i < budget && !(m_scan[u] && m_pos[u] == p); i++) tick();
        found = m_scan[u] && (m_pos[u] == p);
        check("wait_pos", u, 32'(found), 32'd1);
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b0; valid_a = 1'b1; frame_a = $urandom | 32'h1;
        rst_b = 1'b1; en_b = 1'b0; valid_b = 1'b0; frame_b = 32'h0;
        tick();
        tick();
        rst_a = 1'b0; rst_b = 1'b0; valid_a = 1'b0; en_a = 1'b1;
        run(30);

        send(0, 32'hA5C3_0FF0, 40);
        run(2 * 24 + 4);

        send(0, 32'h0000_00FF, 40);
        send(0, 32'hFF00_0000, 40);
        run(2 * 24 + 4);

        for (int k = 0; k < 4; k++) begin
            send(0, $urandom, 40);
            run($urandom_range(1, 30));
        end

        wait_pos(0, 2 * (BL_A + DW) + BL_A + 1, 40);
        en_a = 1'b0;
        run(5);
        en_a = 1'b1;
        run(30);

        wait_pos(0, 0, 40);
        send(0, $urandom | 32'h0000_FF00, 40);
        wait_pos(0, (BL_A + DW) + BL_A + 1, 40);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        run(30);

        en_b = 1'b1;
        send(1, $urandom, 40);
        run(40);
        send(1, $urandom, 40);
        run(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
